// File: rtl/ccd_line_sequencer.sv
// ============================================================================
// ccd_line_sequencer - CCD frame/line sequencer: vertical transfer, horizontal
// clocks, reset gate and ADC enable. Optional macro: CCD_SEQ_CONTINUOUS_EN. Rev 1.0
// ============================================================================
`default_nettype none

module ccd_line_sequencer #(
  parameter int CICLOS_FORMAS_DE_ONDA = 8,
  parameter int PIXELS_PREAMBULO      = 5,
  parameter int PIXELS_POR_LINEA      = 2048,
  parameter int CICLOS_VXFER          = 16
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [15:0] i_num_lines,
`ifdef CCD_SEQ_CONTINUOUS_EN
  input  logic        i_continuous,
`endif
  output logic        o_enable,
  output logic [31:0] o_contador,
  output logic        o_phi_l1,
  output logic        o_phi_l2,
  output logic        o_phi_rg,
  output logic        o_phi_v,
  output logic        o_busy,
  output logic [15:0] o_line_idx,
  output logic        o_line_start,
  output logic        o_line_done,
  output logic        o_frame_done
);

  localparam int LEN = (PIXELS_PREAMBULO + PIXELS_POR_LINEA) * CICLOS_FORMAS_DE_ONDA;
  localparam int PW  = $clog2(CICLOS_FORMAS_DE_ONDA);
  localparam int VW  = (CICLOS_VXFER > 1) ? $clog2(CICLOS_VXFER) : 1;
  localparam logic [31:0]   LAST_CNT = 32'(LEN - 1);
  localparam logic [PW-1:0] HALF     = PW'(CICLOS_FORMAS_DE_ONDA / 2);
  localparam logic [VW-1:0] VX_LAST  = VW'(CICLOS_VXFER - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VXFER = 2'd1,
    LINE  = 2'd2
  } state_t;

  state_t        state;
  logic [VW-1:0] vx_cnt;
  logic [15:0]   last_idx;

  logic [31:0]   cnt_next;
  logic [PW-1:0] phase_next;
  logic          l1_next;
  logic          at_end;
  logic          pre_end;
  logic          last_line;
  logic          continuous;
  logic [15:0]   latch_last;

  assign cnt_next   = o_contador + 32'd1;
  assign phase_next = cnt_next[PW-1:0];
  assign l1_next    = (phase_next < HALF);
  assign at_end     = (o_contador == LAST_CNT);
  assign pre_end    = (cnt_next == LAST_CNT);
  assign last_line  = (o_line_idx == last_idx);
  // A requested line count of zero still produces a single line.
  assign latch_last = (i_num_lines == 16'd0) ? 16'd0 : (i_num_lines - 16'd1);

`ifdef CCD_SEQ_CONTINUOUS_EN
  assign continuous = i_continuous;
`else
  assign continuous = 1'b0;
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      vx_cnt       <= '0;
      last_idx     <= '0;
      o_enable     <= 1'b0;
      o_contador   <= '0;
      o_phi_l1     <= 1'b0;
      o_phi_l2     <= 1'b1;
      o_phi_rg     <= 1'b0;
      o_phi_v      <= 1'b0;
      o_busy       <= 1'b0;
      o_line_idx   <= '0;
      o_line_start <= 1'b0;
      o_line_done  <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_line_start <= 1'b0;
      o_line_done  <= 1'b0;
      o_frame_done <= 1'b0;
      if (i_stop) begin
        state      <= IDLE;
        vx_cnt     <= '0;
        o_enable   <= 1'b0;
        o_contador <= '0;
        o_phi_l1   <= 1'b0;
        o_phi_l2   <= 1'b1;
        o_phi_rg   <= 1'b0;
        o_phi_v    <= 1'b0;
        o_busy     <= 1'b0;
        o_line_idx <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (i_start) begin
              state      <= VXFER;
              vx_cnt     <= '0;
              last_idx   <= latch_last;
              o_line_idx <= '0;
              o_contador <= '0;
              o_phi_v    <= 1'b1;
              o_busy     <= 1'b1;
            end
          end
          VXFER: begin
            if (vx_cnt == VX_LAST) begin
              // First LINE cycle is phase 0: phi_l1 high, reset gate pulsed.
              state        <= LINE;
              o_phi_v      <= 1'b0;
              o_enable     <= 1'b1;
              o_contador   <= '0;
              o_line_start <= 1'b1;
              o_phi_l1     <= 1'b1;
              o_phi_l2     <= 1'b0;
              o_phi_rg     <= 1'b1;
            end else begin
              vx_cnt <= vx_cnt + 1'b1;
            end
          end
          LINE: begin
            if (at_end) begin
              o_enable   <= 1'b0;
              o_contador <= '0;
              o_phi_l1   <= 1'b0;
              o_phi_l2   <= 1'b1;
              o_phi_rg   <= 1'b0;
              if (last_line && !continuous) begin
                state      <= IDLE;
                o_busy     <= 1'b0;
                o_line_idx <= '0;
              end else begin
                state   <= VXFER;
                vx_cnt  <= '0;
                o_phi_v <= 1'b1;
                if (last_line) begin
                  o_line_idx <= '0;
                  last_idx   <= latch_last;
                end else begin
                  o_line_idx <= o_line_idx + 16'd1;
                end
              end
            end else begin
              // Outputs are registered, so the pulses for LEN-1 are set one edge early.
              o_contador <= cnt_next;
              o_phi_l1   <= l1_next;
              o_phi_l2   <= ~l1_next;
              o_phi_rg   <= (phase_next == '0);
              if (pre_end) begin
                o_line_done  <= 1'b1;
                o_frame_done <= last_line;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ccd_line_sequencer.sv
// ============================================================================
// tb_ccd_line_sequencer - self-checking bench for ccd_line_sequencer (LEN=20,
// VXFER=8). Continuous-mode scenario built only with CCD_SEQ_CONTINUOUS_EN. Rev 1.0
// ============================================================================
`default_nettype none

module tb_ccd_line_sequencer;

  localparam int VX  = 8;
  localparam int LN  = 20;
  localparam int PER = VX + LN;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [15:0] num_lines;
`ifdef CCD_SEQ_CONTINUOUS_EN
  logic        continuous;
`endif
  logic        enable;
  logic [31:0] contador;
  logic        phi_l1, phi_l2, phi_rg, phi_v, busy;
  logic [15:0] line_idx;
  logic        line_start, line_done, frame_done;

  always #5 clk = ~clk;

  ccd_line_sequencer #(
    .CICLOS_FORMAS_DE_ONDA(4),
    .PIXELS_PREAMBULO(1),
    .PIXELS_POR_LINEA(4),
    .CICLOS_VXFER(VX)
  ) dut (
    .i_clock(clk),
    .i_reset_n(rst_n),
    .i_start(start),
    .i_stop(stop),
    .i_num_lines(num_lines),
`ifdef CCD_SEQ_CONTINUOUS_EN
    .i_continuous(continuous),
`endif
    .o_enable(enable),
    .o_contador(contador),
    .o_phi_l1(phi_l1),
    .o_phi_l2(phi_l2),
    .o_phi_rg(phi_rg),
    .o_phi_v(phi_v),
    .o_busy(busy),
    .o_line_idx(line_idx),
    .o_line_start(line_start),
    .o_line_done(line_done),
    .o_frame_done(frame_done)
  );

  typedef struct packed {
    logic [31:0] cnt;
    logic [15:0] idx;
    logic busy, en, l1, l2, rg, v, ls, ld, fd;
  } snap_t;

  typedef struct {
    string       name;
    logic [15:0] nl;
    int          stop_at;
    int          glitch_at;
    int          exp_busy;
    int          exp_frames;
    int          exp_lines;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  snap_t sb[$];

  function automatic snap_t idle_snap();
    snap_t s;
    s = '0;
    s.l2 = 1'b1;
    return s;
  endfunction

  // Expected outputs t cycles after the start-accepting edge of an n-line frame.
  function automatic snap_t exp_snap(int t, int n, int stop_at);
    snap_t s;
    int p, c, ln;
    s = idle_snap();
    if ((stop_at >= 0 && t > stop_at) || t >= PER * n) return s;
    p  = t % PER;
    ln = t / PER;
    s.busy = 1'b1;
    s.idx  = 16'(ln);
    if (p < VX) begin
      s.v = 1'b1;
    end else begin
      c      = p - VX;
      s.cnt  = 32'(c);
      s.en   = 1'b1;
      s.l1   = ((c % 4) < 2);
      s.l2   = !((c % 4) < 2);
      s.rg   = ((c % 4) == 0);
      s.ls   = (c == 0);
      s.ld   = (c == LN - 1);
      s.fd   = (c == LN - 1) && (ln == n - 1);
    end
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.cnt = contador; s.idx = line_idx; s.busy = busy; s.en = enable;
    s.l1 = phi_l1; s.l2 = phi_l2; s.rg = phi_rg; s.v = phi_v;
    s.ls = line_start; s.ld = line_done; s.fd = frame_done;
    return s;
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("cnt=%0d idx=%0d busy=%b en=%b l1=%b l2=%b rg=%b v=%b ls=%b ld=%b fd=%b",
                     s.cnt, s.idx, s.busy, s.en, s.l1, s.l2, s.rg, s.v, s.ls, s.ld, s.fd);
  endfunction

  task automatic check_snap(string name, int t, snap_t got, snap_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0d got {%s} expected {%s}", name, t, fmt(got), fmt(want));
    end
  endtask

  task automatic check_int(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic run_vec(vec_t v);
    int n, limit, nb, nf, nl;
    snap_t got;
    n     = (v.nl == 16'd0) ? 1 : int'(v.nl);
    limit = (v.stop_at >= 0) ? v.stop_at + 3 : PER * n + 3;
    nb = 0; nf = 0; nl = 0;
    num_lines = v.nl;
    start     = 1'b1;
    for (int t = 0; t < limit; t++) begin
      sb.push_back(exp_snap(t, n, v.stop_at));
      @(posedge clk); #1;
      start = 1'b0;
      stop  = 1'b0;
      got   = dut_snap();
      check_snap(v.name, t, got, sb.pop_front());
      nb += int'(got.busy);
      nf += int'(got.fd);
      nl += int'(got.ld);
      if (t == v.stop_at)   stop  = 1'b1;
      if (t == v.glitch_at) start = 1'b1;
    end
    check_int({v.name, "_busy_cycles"}, nb, v.exp_busy);
    check_int({v.name, "_frame_done"},  nf, v.exp_frames);
    check_int({v.name, "_line_done"},   nl, v.exp_lines);
  endtask

  vec_t vecs[5];

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; num_lines = 16'd0;
`ifdef CCD_SEQ_CONTINUOUS_EN
    continuous = 1'b0;
`endif
    vecs[0] = '{"two_lines",    16'd2, -1, -1, 56, 1, 2};
    vecs[1] = '{"zero_lines",   16'd0, -1, 15, 28, 1, 1};
    vecs[2] = '{"one_line",     16'd1, -1, -1, 28, 1, 1};
    vecs[3] = '{"three_glitch", 16'd3, -1, 40, 84, 1, 3};
    vecs[4] = '{"stop_mid",     16'd2, 18, -1, 19, 0, 0};

    #12;
    check_snap("reset_state", 0, dut_snap(), idle_snap());
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    check_snap("idle_after_reset", 0, dut_snap(), idle_snap());

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Start and stop together in IDLE must leave the block idle.
    start = 1'b1; stop = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      check_snap("start_stop_idle", t, dut_snap(), idle_snap());
    end
    start = 1'b0; stop = 1'b0;

    // Asynchronous reset in the middle of a LINE.
    num_lines = 16'd2; start = 1'b1;
    for (int t = 0; t < 12; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check_snap("pre_reset_line", 11, dut_snap(), exp_snap(11, 2, -1));
    #2 rst_n = 1'b0;
    #1 check_snap("async_reset", 0, dut_snap(), idle_snap());
    #3 rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      check_snap("no_resume", t, dut_snap(), idle_snap());
    end

`ifdef CCD_SEQ_CONTINUOUS_EN
    begin
      int nf;
      int nb;
      snap_t got;
      nf = 0; nb = 0;
      continuous = 1'b1; num_lines = 16'd1; start = 1'b1;
      for (int t = 0; t < 3 * PER + 3; t++) begin
        sb.push_back((t < 3 * PER) ? exp_snap(t % PER, 1, -1) : idle_snap());
        @(posedge clk); #1;
        start = 1'b0;
        got = dut_snap();
        check_snap("continuous", t, got, sb.pop_front());
        if (t < 3 * PER) nb += int'(got.busy);
        nf += int'(got.fd);
        if (t == 2 * PER + 10) continuous = 1'b0;
      end
      check_int("continuous_busy", nb, 3 * PER);
      check_int("continuous_frames", nf, 3);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
